// File: rtl/bit_timing_configuration.sv
// rtl/bit_timing_configuration.sv - CAN bit-timing sequencer: SYNC/PROP/PHASE1/PHASE2 tq stepping with sample/end strobes
module bit_timing_configuration (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       tq_pulse,
  input  logic [3:0] prop_seg,
  input  logic [3:0] phase_seg1,
  input  logic [3:0] phase_seg2,
  output logic [1:0] current_segment,
  output logic [4:0] quanta_counter,
  output logic [4:0] bit_quanta_counter,
  output logic       sample_point,
  output logic       bit_timing_end,
  output logic       sync_seg_active,
  output logic       prop_seg_active,
  output logic       phase_seg1_active,
  output logic       phase_seg2_active,
  output logic [4:0] total_bit_tq,
  output logic       config_valid
);

  typedef enum logic [1:0] {
    SEG_SYNC = 2'd0,
    SEG_PROP = 2'd1,
    SEG_PH1  = 2'd2,
    SEG_PH2  = 2'd3
  } seg_e;

  seg_e       seg_q, seg_d;
  logic [4:0] qc_q, qc_d;
  logic [4:0] bqc_q, bqc_d;
  logic       sp_q, sp_d;
  logic       bte_q, bte_d;
  logic [4:0] seg_len;
  logic       seg_done;

  function automatic logic len_ok(input logic [3:0] len);
    return (len != 4'd0) && (len <= 4'd8);
  endfunction

  assign config_valid = len_ok(prop_seg) && len_ok(phase_seg1) && len_ok(phase_seg2);
  assign total_bit_tq = 5'd1 + {1'b0, prop_seg} + {1'b0, phase_seg1} + {1'b0, phase_seg2};

  always_comb begin
    seg_len = 5'd1;
    unique case (seg_q)
      SEG_SYNC: seg_len = 5'd1;
      SEG_PROP: seg_len = {1'b0, prop_seg};
      SEG_PH1:  seg_len = {1'b0, phase_seg1};
      SEG_PH2:  seg_len = {1'b0, phase_seg2};
      default:  seg_len = 5'd1;
    endcase
  end

  // >= rather than == so a length shrunk below the current index still ends the segment
  assign seg_done = (qc_q >= (seg_len - 5'd1));

  always_comb begin
    seg_d = seg_q;
    qc_d  = qc_q;
    bqc_d = bqc_q;
    sp_d  = 1'b0;
    bte_d = 1'b0;
    if (!enable || !config_valid) begin
      seg_d = SEG_SYNC;
      qc_d  = 5'd0;
      bqc_d = 5'd0;
    end else if (tq_pulse) begin
      if (seg_done) begin
        qc_d = 5'd0;
        unique case (seg_q)
          SEG_SYNC: begin
            seg_d = SEG_PROP;
            bqc_d = bqc_q + 5'd1;
          end
          SEG_PROP: begin
            seg_d = SEG_PH1;
            bqc_d = bqc_q + 5'd1;
          end
          SEG_PH1: begin
            seg_d = SEG_PH2;
            bqc_d = bqc_q + 5'd1;
            sp_d  = 1'b1;
          end
          SEG_PH2: begin
            seg_d = SEG_SYNC;
            bqc_d = 5'd0;
            bte_d = 1'b1;
          end
          default: seg_d = SEG_SYNC;
        endcase
      end else begin
        qc_d  = qc_q + 5'd1;
        bqc_d = bqc_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q <= SEG_SYNC;
      qc_q  <= 5'd0;
      bqc_q <= 5'd0;
      sp_q  <= 1'b0;
      bte_q <= 1'b0;
    end else begin
      seg_q <= seg_d;
      qc_q  <= qc_d;
      bqc_q <= bqc_d;
      sp_q  <= sp_d;
      bte_q <= bte_d;
    end
  end

  assign current_segment    = seg_q;
  assign quanta_counter     = qc_q;
  assign bit_quanta_counter = bqc_q;
  assign sample_point       = sp_q;
  assign bit_timing_end     = bte_q;
  assign sync_seg_active    = (seg_q == SEG_SYNC);
  assign prop_seg_active    = (seg_q == SEG_PROP);
  assign phase_seg1_active  = (seg_q == SEG_PH1);
  assign phase_seg2_active  = (seg_q == SEG_PH2);

endmodule

// File: tb/tb_bit_timing_configuration.sv
// tb/tb_bit_timing_configuration.sv - bench for bit_timing_configuration against a tq-level reference model
module tb_bit_timing_configuration;

  logic       clock = 1'b0;
  logic       reset, enable, tq_pulse;
  logic [3:0] prop_seg, phase_seg1, phase_seg2;
  logic [1:0] current_segment;
  logic [4:0] quanta_counter, bit_quanta_counter, total_bit_tq;
  logic       sample_point, bit_timing_end, config_valid;
  logic       sync_seg_active, prop_seg_active, phase_seg1_active, phase_seg2_active;

  bit_timing_configuration dut (
    .clock(clock), .reset(reset), .enable(enable), .tq_pulse(tq_pulse),
    .prop_seg(prop_seg), .phase_seg1(phase_seg1), .phase_seg2(phase_seg2),
    .current_segment(current_segment), .quanta_counter(quanta_counter),
    .bit_quanta_counter(bit_quanta_counter), .sample_point(sample_point),
    .bit_timing_end(bit_timing_end), .sync_seg_active(sync_seg_active),
    .prop_seg_active(prop_seg_active), .phase_seg1_active(phase_seg1_active),
    .phase_seg2_active(phase_seg2_active), .total_bit_tq(total_bit_tq),
    .config_valid(config_valid)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int m_seg = 0, m_qc = 0, m_bqc = 0, m_sp = 0, m_bte = 0;

  function automatic int cfg_ok(input int p, input int a, input int b);
    return (p >= 1 && p <= 8 && a >= 1 && a <= 8 && b >= 1 && b <= 8) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic t);
    int lens[4];
    lens = '{1, int'(prop_seg), int'(phase_seg1), int'(phase_seg2)};
    m_sp = 0;
    m_bte = 0;
    if (r || !e || cfg_ok(prop_seg, phase_seg1, phase_seg2) == 0) begin
      m_seg = 0; m_qc = 0; m_bqc = 0;
    end else if (t) begin
      if (m_qc + 1 >= lens[m_seg]) begin
        m_sp  = (m_seg == 2) ? 1 : 0;
        m_bte = (m_seg == 3) ? 1 : 0;
        m_seg = (m_seg + 1) % 4;
        m_qc  = 0;
        m_bqc = (m_bte == 1) ? 0 : m_bqc + 1;
      end else begin
        m_qc++;
        m_bqc++;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] act;
    act = {phase_seg2_active, phase_seg1_active, prop_seg_active, sync_seg_active};
    chk("segment", current_segment, m_seg);
    chk("quanta", quanta_counter, m_qc);
    chk("bit_quanta", bit_quanta_counter, m_bqc);
    chk("sample_point", sample_point, m_sp);
    chk("bit_end", bit_timing_end, m_bte);
    chk("active_flags", act, 32'd1 << m_seg);
    chk("total_bit_tq", total_bit_tq, (1 + prop_seg + phase_seg1 + phase_seg2) % 32);
    chk("config_valid", config_valid, cfg_ok(prop_seg, phase_seg1, phase_seg2));
  endtask

  task automatic step(input logic r, input logic e, input logic t);
    reset = r; enable = e; tq_pulse = t;
    @(posedge clock);
    model_update(r, e, t);
    #1;
    check_all();
  endtask

  task automatic set_cfg(input int p, input int a, input int b);
    prop_seg = 4'(p); phase_seg1 = 4'(a); phase_seg2 = 4'(b);
  endtask

  initial begin
    int exp_seg[7];
    int exp_bqc[7];
    int sp_cnt, bte_cnt, last_bte, found;
    exp_seg = '{1, 1, 2, 2, 3, 3, 0};
    exp_bqc = '{1, 2, 3, 4, 5, 6, 0};
    set_cfg(2, 2, 2);

    step(1, 0, 0);
    step(1, 0, 0);
    chk("reset_seg", current_segment, 0);
    chk("reset_sync_active", sync_seg_active, 1);

    // disabled: pulses ignored
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    chk("idle_total", total_bit_tq, 7);
    chk("idle_valid", config_valid, 1);

    for (int i = 0; i < 7; i++) begin
      step(0, 1, 1);
      chk("dir_seg", current_segment, exp_seg[i]);
      chk("dir_bqc", bit_quanta_counter, exp_bqc[i]);
      chk("dir_sp", sample_point, (i == 4) ? 1 : 0);
      chk("dir_bte", bit_timing_end, (i == 6) ? 1 : 0);
    end

    set_cfg(8, 8, 8);
    bte_cnt = 0;
    for (int i = 0; i < 75; i++) begin
      step(0, 1, 1);
      if (bit_timing_end) begin
        bte_cnt++;
        chk("bte_888_pos", i % 25, 24);
      end
    end
    chk("max_total", total_bit_tq, 25);
    chk("bte_888_count", bte_cnt, 3);
    set_cfg(9, 8, 8);
    for (int i = 0; i < 6; i++) step(0, 1, 1);
    chk("bad_cfg_valid", config_valid, 0);
    chk("bad_cfg_bqc", bit_quanta_counter, 0);

    // live length change mid-bit
    set_cfg(2, 2, 2);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    set_cfg(3, 4, 5);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step(0, 1, 1);
      if (bit_timing_end) found = 1;
    end
    chk("midrun_bte_seen", found, 1);
    for (int i = 0; i < 13; i++) begin
      step(0, 1, 1);
      chk("midrun_sp", sample_point, (i == 7) ? 1 : 0);
      chk("midrun_bte", bit_timing_end, (i == 12) ? 1 : 0);
    end

    // drop enable inside PHASE1
    set_cfg(2, 2, 2);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    chk("in_phase1", phase_seg1_active, 1);
    step(0, 0, 1);
    chk("drop_seg", current_segment, 0);
    chk("drop_qc", quanta_counter, 0);
    chk("drop_sp", sample_point, 0);
    step(0, 1, 1);
    chk("restart_seg", current_segment, 1);

    set_cfg(3, 2, 4);
    step(0, 0, 0);
    sp_cnt = 0; bte_cnt = 0; last_bte = -1;
    for (int i = 0; i < 80; i++) begin
      step(0, 1, 1);
      if (sample_point) sp_cnt++;
      if (bit_timing_end) begin
        bte_cnt++;
        if (last_bte >= 0) chk("bte_spacing", i - last_bte, 10);
        last_bte = i;
      end
    end
    chk("sp_count_80", sp_cnt, 8);
    chk("bte_count_80", bte_cnt, 8);

    // randomized run
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) begin
        if ($urandom_range(0, 4) == 0)
          set_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
        else
          set_cfg($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 8));
      end
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
